left_shift_register_base: RTL and testbench

- Parameterised serial-in, parallel-out shift register; shifts left by one bit per enabled clock.
- New serial bit enters at the LSB; the MSB is discarded.
- Basic building block for serial-to-parallel conversion and bit-pattern capture in the shifting library.

---
 rtl/left_shift_register_base.sv | 63 ++++++
 tb/tb_left_shift_register_base.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/left_shift_register_base.sv
`default_nettype none
// ============================================================================
// Module      : left_shift_register_base
// Description : Parameterised serial-in, parallel-out shift register. Each
//               enabled rising edge shifts the register left by one bit. The
//               serial input enters at the LSB and the MSB is discarded.
//               Reset is synchronous and active-high, and it takes priority
//               over enable.
//
// Parameters  : DEPTH  - number of register stages and width of out (>= 1)
//
// Ports       : clk     in   1      clock, rising-edge active
//               reset   in   1      synchronous active-high clear
//               in      in   1      serial bit shifted into out[0]
//               enable  in   1      shift enable, active-high
//               out     out  DEPTH  register contents; out[0] is the newest
//                                   bit
//
// Revision    : 1.0 - initial release
// ============================================================================
module left_shift_register_base #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             enable,
    output logic [DEPTH-1:0] out
);

    // Register state. out is driven only from this register, so the output
    // has no combinational path from in, enable or reset.
    logic [DEPTH-1:0] r_shift;

    // Next shifted value. It is built per depth because the slice
    // [DEPTH-2:0] does not exist when DEPTH is 1.
    logic [DEPTH-1:0] w_shifted;

    generate
        if (DEPTH == 1) begin : g_single
            // With one stage a shift just replaces the register with in.
            assign w_shifted = in;
        end else begin : g_multi
            // Drop the old MSB, move every other bit up one position, and
            // put the new serial bit in the LSB.
            assign w_shifted = {r_shift[DEPTH-2:0], in};
        end
    endgenerate

    // Reset is checked before enable, so reset wins when both are high.
    // When enable is low the register holds its value and in is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
        end else if (enable) begin
            r_shift <= w_shifted;
        end
    end

    assign out = r_shift;

endmodule
`default_nettype wire

// File: tb/tb_left_shift_register_base.sv
`default_nettype none
// ============================================================================
// Module      : tb_left_shift_register_base
// Description : Self-checking bench for left_shift_register_base. It runs an
//               8-deep and a 1-deep instance from the same stimulus. A model
//               keeps a history of the bits sampled on enabled edges since
//               the last reset, and the register contents are derived from
//               that history. Directed vectors also carry literal
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_left_shift_register_base;

    localparam int c_depth = 8;

    logic               clk;
    logic               reset;
    logic               in;
    logic               enable;
    logic [c_depth-1:0] out8;
    logic [0:0]         out1;

    int total;
    int bad;

    // Model state: the bits sampled on enabled edges since the last reset,
    // oldest first.
    bit hist[$];
    bit model_valid;

    left_shift_register_base #(.DEPTH(c_depth)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .enable (enable),
        .out    (out8)
    );

    left_shift_register_base #(.DEPTH(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .enable (enable),
        .out    (out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected contents of a register of width d: bit k is the k-th most
    // recent sampled bit, or 0 when fewer than k+1 bits have been sampled.
    function automatic logic [c_depth-1:0] model_value(input int d);
        logic [c_depth-1:0] v;
        v = '0;
        for (int k = 0; k < d; k++) begin
            if (k < hist.size()) v[k] = hist[hist.size() - 1 - k];
        end
        return v;
    endfunction

    // Model update. Inputs change only on the falling edge, so they are
    // stable here.
    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            model_valid <= 1'b1;
        end else if (enable) begin
            hist.push_back(in);
        end
    end

    // Compare on every falling edge after the model has seen a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [c_depth-1:0] e8;
            logic [c_depth-1:0] e1;
            e8 = model_value(c_depth);
            e1 = model_value(1);
            total++;
            if (out8 !== e8) begin
                bad++;
                $display("FAIL model8 t=%0t out=%b expected=%b", $time, out8, e8);
            end
            total++;
            if (out1 !== e1[0]) begin
                bad++;
                $display("FAIL model1 t=%0t out=%b expected=%b", $time, out1, e1[0]);
            end
        end
    end

    // Drive one edge: set inputs on the falling edge, then wait until just
    // after the rising edge.
    task automatic step(input logic r, input logic e, input logic i);
        @(negedge clk);
        reset  = r;
        enable = e;
        in     = i;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [c_depth-1:0] exp);
        total++;
        if (out8 !== exp) begin
            bad++;
            $display("FAIL %s out=%b expected=%b", name, out8, exp);
        end
    endtask

    task automatic chk1(input string name, input logic exp);
        total++;
        if (out1 !== exp) begin
            bad++;
            $display("FAIL %s out=%b expected=%b", name, out1, exp);
        end
    endtask

    typedef struct {
        logic       r;
        logic       e;
        logic       i;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        total       = 0;
        bad         = 0;
        model_valid = 1'b0;
        reset       = 1'b1;
        enable      = 1'b1;
        in          = 1'b0;

        // Reset with enable high.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'b00000000});
        // Basic shifting: 1,0,1,0.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b00000001});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'b00000010});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b00000101});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'b00001010});
        // Mid-operation reset while enable=1 and in=1: reset wins.
        vecs.push_back('{1'b1, 1'b1, 1'b1, 8'b00000000});
        // Pattern load: 1,1,0,1,0,1,1.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b00000001});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b00000011});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'b00000110});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b00001101});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'b00011010});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b00110101});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b01101011});
        // Hold across 3 edges with enable=0 and in=1.
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b01101011});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b01101011});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b01101011});
        // Overflow: the MSB is discarded.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b11010111});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'b10101110});
        // Reset with enable low, then enable gating.
        vecs.push_back('{1'b1, 1'b0, 1'b1, 8'b00000000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b00000000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b00000000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b00000000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'b00000000});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 8'b00000001});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'b00000010});

        foreach (vecs[n]) begin
            step(vecs[n].r, vecs[n].e, vecs[n].i);
            chk8($sformatf("vec%0d", n), vecs[n].exp);
            // The single-stage register holds the newest bit, which is
            // also bit 0 of the 8-deep register.
            chk1($sformatf("d1_vec%0d", n), vecs[n].exp[0]);
        end

        // Extra single-stage cases: a hold keeps 1, then reset clears.
        step(1'b0, 1'b1, 1'b1);
        chk1("d1_load1", 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk1("d1_hold", 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk1("d1_reset", 1'b0);
        chk8("reset_end", 8'b00000000);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
